// File: rtl/ysyx_25040109_mdu_seq_if.sv
// Handshake bundle between execute, the RV32M sequencer and writeback.
`timescale 1ns/1ps
interface ysyx_25040109_mdu_seq_if #(
    parameter int XLEN = 32
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      in_funct3;
    logic [XLEN-1:0] in_rs1;
    logic [XLEN-1:0] in_rs2;
    logic [4:0]      in_rd;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;
    logic [4:0]      out_rd;
    logic            busy;

    modport master (
        output flush, in_valid, in_funct3,
        output in_rs1, in_rs2, in_rd, out_ready,
        input  in_ready, out_valid, out_result,
        input  out_rd, busy
    );

    modport slave (
        input  flush, in_valid, in_funct3,
        input  in_rs1, in_rs2, in_rd, out_ready,
        output in_ready, out_valid, out_result,
        output out_rd, busy
    );
endinterface

// File: rtl/ysyx_25040109_mdu_seq.sv
// Multi-cycle RV32M unit: shared shift-add multiplier / restoring divider.
`timescale 1ns/1ps
module ysyx_25040109_mdu_seq #(
    parameter int XLEN = 32
) (
    input logic clk,
    input logic rst_n,
    ysyx_25040109_mdu_seq_if.slave io
);
    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE, CALC, FIXUP, DONE
    } state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        f3_q, f3_d;
    logic [4:0]        rd_q, rd_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic              qneg_q, qneg_d;
    logic              rneg_q, rneg_d;
    logic [XLEN-1:0]   res_q, res_d;
    logic [4:0]        ord_q, ord_d;
    logic              vld_q, vld_d;
    logic              busy_q, busy_d;

    logic            accept;
    logic            is_div;
    logic            a_sgn, b_sgn;
    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_abs, b_abs;
    logic            div_zero, div_ovf;
    logic [XLEN-1:0] spec_res;

    assign io.in_ready = (state_q == IDLE) && !io.flush;
    assign accept = io.in_valid && io.in_ready;
    assign is_div = io.in_funct3[2];

    // MULHSU keeps rs1 signed; DIVU/REMU and MULHU see raw bits
    assign a_sgn = is_div ? !io.in_funct3[0]
                          : (io.in_funct3 != 3'b011);
    assign b_sgn = is_div ? !io.in_funct3[0]
                          : !io.in_funct3[1];
    assign a_neg = a_sgn && io.in_rs1[XLEN-1];
    assign b_neg = b_sgn && io.in_rs2[XLEN-1];
    assign a_abs = a_neg ? -io.in_rs1 : io.in_rs1;
    assign b_abs = b_neg ? -io.in_rs2 : io.in_rs2;

    assign div_zero = is_div && (io.in_rs2 == '0);
    assign div_ovf  = is_div && !io.in_funct3[0]
                   && (io.in_rs1 == MIN)
                   && (io.in_rs2 == '1);

    always_comb begin
        spec_res = '0;
        if (io.in_funct3[1]) begin
            spec_res = div_zero ? io.in_rs1 : '0;
        end else begin
            spec_res = div_zero ? '1 : MIN;
        end
    end

    // multiplier bit sits in acc[0]; partial sum rides in the high half
    logic [XLEN:0]     msum;
    logic [2*XLEN-1:0] mul_next;
    assign msum = {1'b0, acc_q[2*XLEN-1:XLEN]}
                + (acc_q[0] ? {1'b0, opb_q} : '0);
    assign mul_next = {msum, acc_q[XLEN-1:1]};

    // high half is the partial remainder, low half shifts in quotient bits
    logic [XLEN:0]     dcand, ddiff;
    logic              dge;
    logic [2*XLEN-1:0] div_next;
    assign dcand = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    assign ddiff = dcand - {1'b0, opb_q};
    assign dge   = !ddiff[XLEN];
    assign div_next = {dge ? ddiff[XLEN-1:0] : dcand[XLEN-1:0],
                       acc_q[XLEN-2:0], dge};

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem, fix_res;
    assign prod = qneg_q ? -acc_q : acc_q;
    assign quo  = qneg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    assign rem  = rneg_q ? -acc_q[2*XLEN-1:XLEN]
                         : acc_q[2*XLEN-1:XLEN];

    always_comb begin
        fix_res = '0;
        unique case (1'b1)
            (f3_q == 3'b000):     fix_res = prod[XLEN-1:0];
            (f3_q[2] == 1'b0 && f3_q != 3'b000):
                                  fix_res = prod[2*XLEN-1:XLEN];
            (f3_q[2:1] == 2'b10): fix_res = quo;
            (f3_q[2:1] == 2'b11): fix_res = rem;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        f3_d    = f3_q;
        rd_d    = rd_q;
        opb_d   = opb_q;
        acc_d   = acc_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        res_d   = res_q;
        ord_d   = ord_q;
        if (io.flush) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: if (accept) begin
                    f3_d   = io.in_funct3;
                    rd_d   = io.in_rd;
                    cnt_d  = '0;
                    qneg_d = a_neg ^ b_neg;
                    rneg_d = a_neg;
                    opb_d  = is_div ? b_abs : a_abs;
                    acc_d  = {{XLEN{1'b0}}, is_div ? a_abs : b_abs};
                    if (div_zero || div_ovf) begin
                        res_d   = spec_res;
                        ord_d   = io.in_rd;
                        state_d = DONE;
                    end else begin
                        state_d = CALC;
                    end
                end
                CALC: begin
                    acc_d = f3_q[2] ? div_next : mul_next;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(XLEN-1)) state_d = FIXUP;
                end
                FIXUP: begin
                    res_d   = fix_res;
                    ord_d   = rd_q;
                    state_d = DONE;
                end
                DONE: if (io.out_ready) state_d = IDLE;
            endcase
        end
        vld_d  = (state_d == DONE);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            f3_q    <= '0;
            rd_q    <= '0;
            opb_q   <= '0;
            acc_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            res_q   <= '0;
            ord_q   <= '0;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            f3_q    <= f3_d;
            rd_q    <= rd_d;
            opb_q   <= opb_d;
            acc_q   <= acc_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            res_q   <= res_d;
            ord_q   <= ord_d;
            vld_q   <= vld_d;
            busy_q  <= busy_d;
        end
    end

    assign io.out_valid  = vld_q;
    assign io.out_result = res_q;
    assign io.out_rd     = ord_q;
    assign io.busy       = busy_q;
endmodule

// File: tb/tb_ysyx_25040109_mdu_seq.sv
// Directed bench for the RV32M sequencer: results, latency, stalls, flush, reset.
`timescale 1ns/1ps
module tb_ysyx_25040109_mdu_seq;
    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   hits;

    ysyx_25040109_mdu_seq_if #(.XLEN(XLEN)) io ();

    ysyx_25040109_mdu_seq #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] want);
        n_cmp++;
        assert (got === want) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h",
                   tag, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string tag,
                          input logic [2:0] f3,
                          input logic [31:0] a,
                          input logic [31:0] b,
                          input logic [4:0] rd,
                          input logic [31:0] want,
                          input int lat);
        int n;
        io.in_funct3 = f3;
        io.in_rs1    = a;
        io.in_rs2    = b;
        io.in_rd     = rd;
        io.in_valid  = 1'b1;
        step();
        io.in_valid  = 1'b0;
        io.in_rs1    = $urandom;
        io.in_rs2    = $urandom;
        io.in_rd     = 5'($urandom);
        n = 1;
        while (!io.out_valid && n < 60) begin
            step();
            n++;
        end
        chk({tag, " lat"}, 64'(n), 64'(lat));
        chk({tag, " res"}, 64'(io.out_result), 64'(want));
        chk({tag, " rd"}, 64'(io.out_rd), 64'(rd));
        io.out_ready = 1'b1;
        step();
        io.out_ready = 1'b0;
        chk({tag, " drop"}, {62'd0, io.out_valid, io.busy}, 64'd0);
    endtask

    initial begin
        io.flush     = 1'b0;
        io.in_valid  = 1'b0;
        io.in_funct3 = 3'b000;
        io.in_rs1    = '0;
        io.in_rs2    = '0;
        io.in_rd     = '0;
        io.out_ready = 1'b0;
        #12;
        chk("reset", {io.out_valid, io.busy, io.out_result,
                      io.out_rd, io.in_ready},
            {2'b00, 32'd0, 5'd0, 1'b1});
        rst_n = 1'b1;
        step();

        run_op("mul",    3'b000, 32'hFFFFFFFF, 32'h2, 5'd5,
               32'hFFFFFFFE, 34);
        run_op("mulh",   3'b001, 32'hFFFFFFFF, 32'h2, 5'd5,
               32'hFFFFFFFF, 34);
        run_op("mulhsu", 3'b010, 32'hFFFFFFFF, 32'h2, 5'd5,
               32'hFFFFFFFF, 34);
        run_op("mulhu",  3'b011, 32'hFFFFFFFF, 32'h2, 5'd5,
               32'h00000001, 34);
        run_op("mulh_min", 3'b001, 32'h80000000, 32'h80000000,
               5'd6, 32'h40000000, 34);
        run_op("div",  3'b100, 32'hFFFFFFF9, 32'h2, 5'd7,
               32'hFFFFFFFD, 34);
        run_op("rem",  3'b110, 32'hFFFFFFF9, 32'h2, 5'd8,
               32'hFFFFFFFF, 34);
        run_op("divu", 3'b101, 32'h7, 32'h2, 5'd9,
               32'h3, 34);
        run_op("remu", 3'b111, 32'h7, 32'h2, 5'd10,
               32'h1, 34);
        run_op("div_min2", 3'b100, 32'h80000000, 32'h2, 5'd11,
               32'hC0000000, 34);

        run_op("divu_z", 3'b101, 32'h55, 32'h0, 5'd12,
               32'hFFFFFFFF, 1);
        run_op("rem_z",  3'b110, 32'h1234, 32'h0, 5'd13,
               32'h1234, 1);
        run_op("div_ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF,
               5'd14, 32'h80000000, 1);
        run_op("rem_ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF,
               5'd15, 32'h0, 1);

        io.in_funct3 = 3'b000;
        io.in_rs1    = 32'h1234;
        io.in_rs2    = 32'h10;
        io.in_rd     = 5'd9;
        io.in_valid  = 1'b1;
        step();
        io.in_valid  = 1'b0;
        hits = 0;
        while (!io.out_valid && hits < 60) begin
            step();
            hits++;
        end
        for (int i = 0; i < 10; i++) begin
            chk("bp hold", {24'd0, io.out_result, io.out_rd,
                            io.in_ready, io.busy, io.out_valid},
                {24'd0, 32'h12340, 5'd9, 3'b011});
            step();
        end
        io.out_ready = 1'b1;
        step();
        io.out_ready = 1'b0;
        chk("bp release", {61'd0, io.out_valid, io.busy,
                           io.in_ready}, 64'b001);
        chk("bp held res", 64'(io.out_result), 64'h12340);

        io.in_funct3 = 3'b000;
        io.in_rs1    = 32'd5;
        io.in_rs2    = 32'd5;
        io.in_rd     = 5'd4;
        io.in_valid  = 1'b1;
        step();
        io.in_valid  = 1'b0;
        repeat (10) step();
        chk("fl busy pre", 64'(io.busy), 64'd1);
        io.flush = 1'b1;
        step();
        io.flush = 1'b0;
        chk("fl kill", {62'd0, io.out_valid, io.busy}, 64'd0);
        hits = 0;
        repeat (40) begin
            step();
            if (io.out_valid) hits++;
        end
        chk("fl no out", 64'(hits), 64'd0);

        io.flush    = 1'b1;
        io.in_valid = 1'b1;
        #1;
        chk("fl in_ready", 64'(io.in_ready), 64'd0);
        step();
        io.in_valid = 1'b0;
        io.flush    = 1'b0;
        chk("fl no accept", 64'(io.busy), 64'd0);
        step();
        chk("fl still idle", {62'd0, io.busy, io.out_valid}, 64'd0);

        io.in_funct3 = 3'b000;
        io.in_rs1    = 32'd7;
        io.in_rs2    = 32'd9;
        io.in_rd     = 5'd2;
        io.in_valid  = 1'b1;
        step();
        io.in_valid  = 1'b0;
        repeat (5) step();
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst async", {io.out_valid, io.busy, io.out_result,
                          io.out_rd}, 64'd0);
        #2;
        rst_n = 1'b1;
        step();
        chk("rst ready", {62'd0, io.in_ready, io.busy}, 64'b10);
        run_op("mul_post", 3'b000, 32'd3, 32'd4, 5'd3,
               32'd12, 34);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
